ob_cn_mtr_arb: RTL and testbench

//  Consumer end of the conditional-table maturity interface. Accepts matured commands
//  (mtr_vld_r/mtr_r, back-pressured by mtr_accept) into a small queue. Merges them with
//  the ingress command stream into one registered command stream toward the match engine.

---
 rtl/ob_pkg.sv | 18 +
 rtl/ob_cn_mtr_q.sv | 71 +++++++
 rtl/ob_cn_mtr_arb.sv | 104 ++++++++++
 tb/tb_ob_cn_mtr_arb.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ob_pkg.sv
// Shared types and defaults for the ob command path.
package ob_pkg;

    typedef struct packed {
        logic [3:0]  opc;
        logic [11:0] key;
    } cmd_t;

    typedef enum logic [1:0] {
        GRANT_NONE,
        GRANT_IN,
        GRANT_MTR
    } grant_t;

    localparam int OB_CN_MTR_Q_N  = 4;
    localparam int OB_CN_STARVE_N = 8;

endpackage

// File: rtl/ob_cn_mtr_q.sv
// Small synchronous FIFO holding matured commands until the arbiter pops them.
// Count and flags are registered so the arbiter sees clean state-only inputs.
module ob_cn_mtr_q
    import ob_pkg::*;
#(
    parameter int N = OB_CN_MTR_Q_N
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  cmd_t                       din,
    input  logic                       pop,
    output cmd_t                       head,
    output logic [$clog2(N+1)-1:0]     cnt_r,
    output logic                       full_r,
    output logic                       empty_r
);

    localparam int PW = $clog2(N);
    localparam int CW = $clog2(N+1);

    cmd_t             mem [N];
    logic [PW-1:0]    wr_ptr_r;
    logic [PW-1:0]    rd_ptr_r;
    logic [CW-1:0]    cnt_nxt;
    logic             push_ok;
    logic             pop_ok;

    // Guard against overflow/underflow even if a caller misbehaves.
    assign push_ok = push & ~full_r;
    assign pop_ok  = pop & ~empty_r;
    assign head    = mem[rd_ptr_r];

    // Next occupancy: a simultaneous push and pop leaves it unchanged.
    always_comb begin
        cnt_nxt = cnt_r;
        if (push_ok && !pop_ok) begin
            cnt_nxt = cnt_r + 1'b1;
        end else if (!push_ok && pop_ok) begin
            cnt_nxt = cnt_r - 1'b1;
        end
    end

    // Storage write; contents need no reset because empty_r gates every read.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_r] <= din;
        end
    end

    // Pointers wrap naturally since N is a power of two.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            cnt_r    <= '0;
            full_r   <= 1'b0;
            empty_r  <= 1'b1;
        end else begin
            if (push_ok) wr_ptr_r <= wr_ptr_r + 1'b1;
            if (pop_ok)  rd_ptr_r <= rd_ptr_r + 1'b1;
            cnt_r   <= cnt_nxt;
            full_r  <= (cnt_nxt == CW'(N));
            empty_r <= (cnt_nxt == '0);
        end
    end

    a_no_pop_empty: assert property (@(posedge clk) disable iff (!rst) !(pop && empty_r));
    a_no_push_full: assert property (@(posedge clk) disable iff (!rst) !(push && full_r));

endmodule

// File: rtl/ob_cn_mtr_arb.sv
// Merges queued matured commands with the ingress stream into one registered
// command stream. Matured commands win, but ingress is forced through after
// STARVE_N consecutive matured grants while it waits.
module ob_cn_mtr_arb
    import ob_pkg::*;
#(
    parameter int MTR_Q_N  = OB_CN_MTR_Q_N,
    parameter int STARVE_N = OB_CN_STARVE_N
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           in_vld_r,
    input  cmd_t                           in_cmd_r,
    output logic                           in_accept,
    input  logic                           mtr_vld_r,
    input  cmd_t                           mtr_r,
    output logic                           mtr_accept,
    output logic                           out_vld_r,
    output cmd_t                           out_cmd_r,
    input  logic                           out_accept,
    output logic [$clog2(MTR_Q_N+1)-1:0]   mtr_cnt_r,
    output logic                           full_r
);

    localparam int SW = $clog2(STARVE_N+1);

    logic             out_ready;
    logic             q_push;
    logic             q_pop;
    logic             q_empty;
    cmd_t             q_head;
    logic             starve_max;
    logic [SW-1:0]    starve_cnt_r;
    grant_t           grant;

    assign out_ready  = ~out_vld_r | out_accept;
    assign starve_max = (starve_cnt_r == SW'(STARVE_N));
    assign mtr_accept = ~full_r;
    assign q_push     = mtr_vld_r & mtr_accept;
    assign q_pop      = out_ready & (grant == GRANT_MTR);
    // Gated by reset so nothing is consumed from ingress while the block is held.
    assign in_accept  = rst & out_ready & (grant == GRANT_IN);

    ob_cn_mtr_q #(.N(MTR_Q_N)) u_mtr_q (
        .clk     (clk),
        .rst     (rst),
        .push    (q_push),
        .din     (mtr_r),
        .pop     (q_pop),
        .head    (q_head),
        .cnt_r   (mtr_cnt_r),
        .full_r  (full_r),
        .empty_r (q_empty)
    );

    // Priority pick: matured first unless queue empty or ingress has starved.
    always_comb begin
        grant = GRANT_NONE;
        if (in_vld_r && (q_empty || starve_max)) begin
            grant = GRANT_IN;
        end else if (!q_empty) begin
            grant = GRANT_MTR;
        end
    end

    // Output register: load the granted command whenever the slot can advance.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_vld_r <= 1'b0;
            out_cmd_r <= '0;
        end else if (out_ready) begin
            case (grant)
                GRANT_IN: begin
                    out_cmd_r <= in_cmd_r;
                    out_vld_r <= 1'b1;
                end
                GRANT_MTR: begin
                    out_cmd_r <= q_head;
                    out_vld_r <= 1'b1;
                end
                default: begin
                    out_vld_r <= 1'b0;
                end
            endcase
        end
    end

    // Count matured grants taken while ingress waits; clear when ingress goes idle or wins.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            starve_cnt_r <= '0;
        end else if (!in_vld_r) begin
            starve_cnt_r <= '0;
        end else if (out_ready && grant == GRANT_IN) begin
            starve_cnt_r <= '0;
        end else if (out_ready && grant == GRANT_MTR && !starve_max) begin
            starve_cnt_r <= starve_cnt_r + 1'b1;
        end
    end

    a_out_stable: assert property (@(posedge clk) disable iff (!rst)
        (out_vld_r && !out_accept) |=> $stable(out_cmd_r));

endmodule

// File: tb/tb_ob_cn_mtr_arb.sv
// Directed + randomized bench for ob_cn_mtr_arb with a queue-based reference model.
module tb_ob_cn_mtr_arb;
    import ob_pkg::*;

    localparam int QN = 4;
    localparam int SN = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_vld_r;
    cmd_t        in_cmd_r;
    logic        in_accept;
    logic        mtr_vld_r;
    cmd_t        mtr_r;
    logic        mtr_accept;
    logic        out_vld_r;
    cmd_t        out_cmd_r;
    logic        out_accept;
    logic [2:0]  mtr_cnt_r;
    logic        full_r;

    ob_cn_mtr_arb #(.MTR_Q_N(QN), .STARVE_N(SN)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_vld_r   (in_vld_r),
        .in_cmd_r   (in_cmd_r),
        .in_accept  (in_accept),
        .mtr_vld_r  (mtr_vld_r),
        .mtr_r      (mtr_r),
        .mtr_accept (mtr_accept),
        .out_vld_r  (out_vld_r),
        .out_cmd_r  (out_cmd_r),
        .out_accept (out_accept),
        .mtr_cnt_r  (mtr_cnt_r),
        .full_r     (full_r)
    );

    always #5 clk = ~clk;

    // reference model state
    cmd_t mq[$];
    cmd_t m_out;
    bit   m_vld;
    int   m_starve;
    bit   m_in_acc;
    bit   m_mtr_acc;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic cmd_t rnd_cmd(input logic [3:0] opc);
        cmd_t c;
        c.opc = opc;
        c.key = 12'($urandom);
        return c;
    endfunction

    task automatic model_reset();
        mq.delete();
        m_out    = '0;
        m_vld    = 1'b0;
        m_starve = 0;
    endtask

    // One clock: called just after a negedge with inputs already driven.
    task automatic cyc();
        bit ordy, gin, gmtr;
        ordy = !m_vld || out_accept;
        gin  = in_vld_r && (mq.size() == 0 || m_starve == SN);
        gmtr = !gin && mq.size() != 0;
        m_in_acc  = ordy && gin;
        m_mtr_acc = mq.size() < QN;
        #1;
        chk("in_accept", in_accept, m_in_acc);
        chk("mtr_accept", mtr_accept, m_mtr_acc);
        @(posedge clk);
        if (ordy) begin
            if (gin) begin
                m_out = in_cmd_r;
                m_vld = 1'b1;
                m_starve = 0;
            end else if (gmtr) begin
                m_out = mq.pop_front();
                m_vld = 1'b1;
                m_starve = in_vld_r ? ((m_starve < SN) ? m_starve + 1 : SN) : 0;
            end else begin
                m_vld = 1'b0;
                m_starve = 0;
            end
        end else if (!in_vld_r) begin
            m_starve = 0;
        end
        if (mtr_vld_r && m_mtr_acc) mq.push_back(mtr_r);
        @(negedge clk);
        #1;
        chk("out_vld", out_vld_r, m_vld);
        chk("out_cmd", out_cmd_r, m_out);
        chk("mtr_cnt", mtr_cnt_r, mq.size());
        chk("full", full_r, mq.size() == QN);
    endtask

    initial begin
        int run;
        bit seen_in;
        cmd_t held;
        bit stalled;

        // 1: reset with random inputs
        rst = 1'b0;
        model_reset();
        for (int i = 0; i < 4; i++) begin
            in_vld_r   = 1'($urandom);
            in_cmd_r   = rnd_cmd(4'($urandom));
            mtr_vld_r  = 1'($urandom);
            mtr_r      = rnd_cmd(4'($urandom));
            out_accept = 1'($urandom);
            #1;
            chk("rst_out_vld", out_vld_r, 1'b0);
            chk("rst_mtr_cnt", mtr_cnt_r, 3'd0);
            chk("rst_mtr_accept", mtr_accept, 1'b1);
            chk("rst_in_accept", in_accept, 1'b0);
            chk("rst_full", full_r, 1'b0);
            @(negedge clk);
        end
        rst = 1'b1;
        in_vld_r = 1'b1;
        in_cmd_r = rnd_cmd(4'd2);
        mtr_vld_r = 1'b0;
        out_accept = 1'b1;
        cyc();

        // 2: ingress only, back-to-back
        for (int i = 0; i < 10; i++) begin
            in_cmd_r = rnd_cmd(4'd2);
            cyc();
        end
        in_vld_r = 1'b0;
        cyc();
        cyc();

        // 3: fill queue with output stalled
        out_accept = 1'b0;
        mtr_vld_r = 1'b1;
        for (int i = 0; i < 5; i++) begin
            mtr_r = cmd_t'({4'd1, 12'(i)});
            cyc();
        end
        chk("fill_cnt", mtr_cnt_r, 3'd4);
        chk("fill_full", full_r, 1'b1);
        chk("fill_out_vld", out_vld_r, 1'b1);
        mtr_r = cmd_t'({4'd1, 12'd5});
        cyc();
        mtr_vld_r = 1'b0;
        out_accept = 1'b1;
        for (int i = 0; i < 6; i++) cyc();

        // 4: starvation with both sources held
        mtr_vld_r = 1'b1;
        mtr_r = rnd_cmd(4'd1);
        for (int i = 0; i < 3; i++) begin
            cyc();
            mtr_r = rnd_cmd(4'd1);
        end
        in_vld_r = 1'b1;
        in_cmd_r = rnd_cmd(4'd2);
        run = 0;
        seen_in = 1'b0;
        for (int i = 0; i < 32; i++) begin
            cyc();
            if (m_in_acc) in_cmd_r = rnd_cmd(4'd2);
            if (m_mtr_acc) mtr_r = rnd_cmd(4'd1);
            if (out_vld_r && out_cmd_r.opc == 4'd2) begin
                if (seen_in) chk("starve_run", run, SN);
                seen_in = 1'b1;
                run = 0;
            end else begin
                run++;
            end
        end
        in_vld_r = 1'b0;
        mtr_vld_r = 1'b0;
        for (int i = 0; i < 6; i++) cyc();

        // 5: random mixed traffic with toggling back-pressure
        in_vld_r = 1'b0;
        mtr_vld_r = 1'b0;
        for (int i = 0; i < 200; i++) begin
            out_accept = ~out_accept;
            stalled = m_vld && !out_accept;
            held = m_out;
            cyc();
            if (stalled) chk("stall_hold", out_cmd_r, held);
            if (!in_vld_r || m_in_acc) begin
                in_vld_r = 1'($urandom);
                in_cmd_r = rnd_cmd(4'd2);
            end
            if (!mtr_vld_r || m_mtr_acc) begin
                mtr_vld_r = ($urandom_range(0, 3) != 0);
                mtr_r = rnd_cmd(4'd1);
            end
        end
        in_vld_r = 1'b0;
        mtr_vld_r = 1'b0;
        out_accept = 1'b1;
        for (int i = 0; i < 8; i++) cyc();

        // 6: async reset with 3 queued and output valid
        out_accept = 1'b0;
        mtr_vld_r = 1'b1;
        for (int i = 0; i < 4; i++) begin
            mtr_r = rnd_cmd(4'd1);
            cyc();
        end
        mtr_vld_r = 1'b0;
        chk("pre_rst_cnt", mtr_cnt_r, 3'd3);
        chk("pre_rst_vld", out_vld_r, 1'b1);
        #1;
        rst = 1'b0;
        #1;
        chk("arst_out_vld", out_vld_r, 1'b0);
        chk("arst_out_cmd", out_cmd_r, 16'h0);
        chk("arst_mtr_cnt", mtr_cnt_r, 3'd0);
        chk("arst_full", full_r, 1'b0);
        chk("arst_mtr_accept", mtr_accept, 1'b1);
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        out_accept = 1'b1;
        for (int i = 0; i < 5; i++) cyc();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
